// File: rtl/serial_subtractor_pkg.sv
// Shared types and reset values for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic RST_BUSY   = 1'b0;
    localparam logic RST_DONE   = 1'b0;
    localparam logic RST_BOUT   = 1'b0;
    localparam logic RST_OVF    = 1'b0;
    localparam logic RST_BORROW = 1'b0;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, start/done handshake.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   diff_sr;
    logic               borrow;
    logic [CNT_W-1:0]   cnt;
    logic               d_bit;
    logic               borrow_nxt;
    logic [WIDTH-1:0]   diff_shifted;
    logic               last_bit;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic               a_msb;
    logic               b_msb;
`endif

    full_subtractor u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow),
        .d    (d_bit),
        .bout (borrow_nxt)
    );

    // New result bit enters at the MSB; written as shifts so WIDTH=1 stays legal.
    assign diff_shifted = (diff_sr >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    assign last_bit     = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= RST_BUSY;
            done    <= RST_DONE;
            diff    <= '0;
            bout    <= RST_BOUT;
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            borrow  <= RST_BORROW;
            cnt     <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf     <= RST_OVF;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        diff_sr <= '0;
                        borrow  <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        a_msb   <= a[WIDTH-1];
                        b_msb   <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    borrow  <= borrow_nxt;
                    diff_sr <= diff_shifted;
                    cnt     <= cnt + CNT_W'(1);
                    // Final bit: publish the result as DONE is entered.
                    if (last_bit) begin
                        state <= DONE;
                        done  <= 1'b1;
                        diff  <= diff_shifted;
                        bout  <= borrow_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf   <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
